snoopy_bus_controller: RTL and testbench
========================================

Name: snoopy_bus_controller

Overview:
- Owns the shared snoopy bus between NUMBER_OF_CACHES cache controllers and the RAM.
- Arbitrates bus requests round-robin and broadcasts the winner's command to all snoopers.
- Collects the shared and flush responses, sequences the flush write and the memory read on the RAM handshake, then signals completion to the winner.
- Sits between the per-cache CPU/snoopy controllers (MESI protocol blocks) and the RAM port.

Parameters:
NUMBER_OF_CACHES, 4, number of requesters/snoopers (>=2)
ADDRESS_WIDTH, 16, bus/RAM address width
DATA_WIDTH, 16, bus/RAM data width

Ports:
clock  input  1  system clock; single clock domain
reset  input  1  synchronous, active-high reset
request  input  NUMBER_OF_CACHES  per-cache bus request; held until done
commandIn  input  NUMBER_OF_CACHES x command_t  per-cache requested bus command
addressIn  input  NUMBER_OF_CACHES x ADDRESS_WIDTH  per-cache requested address
grant  output  NUMBER_OF_CACHES  one-hot grant, held for the whole transaction
busValid  output  1  high for exactly the SNOOP cycle; snoopers evaluate commandOut/addressOut
commandOut  output  command_t  broadcast command; NONE when idle
addressOut  output  ADDRESS_WIDTH  broadcast address
sharedOut  input  NUMBER_OF_CACHES  per-snooper shared response
ramWriteRequired  input  NUMBER_OF_CACHES  per-snooper flush-required response
flushData  input  NUMBER_OF_CACHES x DATA_WIDTH  per-snooper flush data, valid in SNOOP
sharedIn  output  1  OR of sharedOut over non-granted caches, registered
dataOut  output  DATA_WIDTH  line data returned to the winner
done  output  NUMBER_OF_CACHES  one-cycle completion pulse, one-hot
ramRead  output  1  RAM read request
ramWrite  output  1  RAM write request
ramAddress  output  ADDRESS_WIDTH  RAM address
ramWriteData  output  DATA_WIDTH  RAM write data
ramReadData  input  DATA_WIDTH  RAM read data, valid with ramAck
ramAck  input  1  RAM completion, one cycle
protocolError  output  1  sticky; multiple ramWriteRequired seen in one SNOOP

Behaviour:
- Reset (synchronous): state IDLE, round-robin pointer 0 (cache 0 highest priority). grant, done, busValid, sharedIn, ramRead, ramWrite and protocolError are 0. commandOut is NONE. addressOut, dataOut, ramAddress and ramWriteData are 0.
- Reset asserted mid-transaction aborts it immediately; no done is issued.
- IDLE:
  - If any request is high, select winner w: the first requesting index at or after the pointer, wrapping modulo NUMBER_OF_CACHES.
  - Register grant[w], commandOut=commandIn[w] and addressOut=addressIn[w], then go to SNOOP.
  - The pointer becomes w+1 mod NUMBER_OF_CACHES.
  - A request with commandIn=NONE is granted and completes as an invalidate, without RAM access.
- SNOOP (one cycle, busValid=1):
  - sharedIn <= OR of sharedOut[i] for i!=w.
  - Flush index f = lowest i!=w with ramWriteRequired[i]; capture flushData[f].
  - If more than one such i, set protocolError; it clears only on reset.
  - Next state: FLUSH if f exists; else MEM_READ if the command is BUS_READ or BUS_READ_EXCLUSIVE; else DONE.
- FLUSH:
  - ramWrite=1, ramAddress=addressOut, ramWriteData=captured flush data.
  - Held until the cycle ramAck=1, then ramWrite drops and the block goes to MEM_READ (read/readEx) or DONE (invalidate).
- MEM_READ:
  - ramRead=1, ramAddress=addressOut, held until ramAck.
  - On ack, dataOut <= ramReadData, then go to DONE.
- DONE:
  - done[w]=1 for one cycle; grant still held; sharedIn and dataOut stable.
  - Next cycle returns to IDLE: grant cleared, commandOut=NONE, sharedIn=0.
- Minimum latency from request sampled to done high:
  - Invalidate: 2 cycles (IDLE→SNOOP→DONE).
  - Read, no flush, ack on first cycle: 3 cycles.
- Back-to-back transactions have at least one IDLE cycle between them.
- ramRead and ramWrite are never both high.
- ramAck outside FLUSH/MEM_READ is ignored.
- request deasserted mid-transaction: the transaction still completes and done still pulses.
- Inputs from the winner are sampled only in IDLE.

Decomposition:
- Package: command_t (NONE, BUS_READ, BUS_READ_EXCLUSIVE, BUS_INVALIDATE) from the existing commands package, unchanged.
- New package snoopy_bus_controller_pkg holds the controller state enum (IDLE, SNOOP, FLUSH, MEM_READ, DONE).
- Sub-module round_robin_arbiter, parameterised on NUMBER_OF_CACHES:
  - Inputs: request vector, pointer.
  - Outputs: one-hot winner and its index; purely combinational.
  - The pointer register lives in the controller.

Test Plan:
- Reset, then cache 2 requests BUS_INVALIDATE at 0x0040 -> busValid for one cycle with commandOut=BUS_INVALIDATE and addressOut=0x0040; done[2] two cycles after request sampled; ramRead and ramWrite never high.
- Cache 0 issues BUS_READ at 0x0010; cache 1 asserts sharedOut; RAM acks after 3 cycles with 0xBEEF -> sharedIn=1; dataOut=0xBEEF; done[0] one cycle after ack.
- Cache 1 issues BUS_READ at 0x0020; cache 3 asserts ramWriteRequired with flushData=0x1234 -> ramWrite with ramWriteData=0x1234 until ack, then ramRead at 0x0020, then done[1]; ramRead and ramWrite never overlap.
- All four caches hold requests continuously (invalidates) -> grant order 0,1,2,3,0; each done is one-hot; no starvation.
- Caches 2 and 3 both assert ramWriteRequired during one SNOOP -> protocolError rises and stays high; cache 2's data is flushed; reset clears the flag.
- Reset asserted during MEM_READ -> next cycle state IDLE, grant=0, ramRead=0, done never pulses.

Source files
------------

// File: rtl/commands.sv
// Bus command encoding shared by the cache controllers and the snoopy bus.
package commands;
    typedef enum logic [1:0] {
        NONE               = 2'd0,
        BUS_READ           = 2'd1,
        BUS_READ_EXCLUSIVE = 2'd2,
        BUS_INVALIDATE     = 2'd3
    } command_t;
endpackage

// File: rtl/snoopy_bus_controller_pkg.sv
// Controller state encoding and command helpers for the snoopy bus controller.
package snoopy_bus_controller_pkg;
    import commands::*;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SNOOP    = 3'd1,
        FLUSH    = 3'd2,
        MEM_READ = 3'd3,
        DONE     = 3'd4
    } state_t;

    function automatic logic needs_memory_read(command_t cmd);
        return (cmd == BUS_READ) || (cmd == BUS_READ_EXCLUSIVE);
    endfunction
endpackage

// File: rtl/snoopy_bus_controller_round_robin_arbiter.sv
// Combinational round-robin pick: first requester at or after the pointer, wrapping.
module round_robin_arbiter #(
    parameter int NUMBER_OF_CACHES = 4,
    localparam int PW = $clog2(NUMBER_OF_CACHES)
) (
    input  logic [NUMBER_OF_CACHES-1:0] i_request,
    input  logic [PW-1:0]               i_pointer,
    output logic [NUMBER_OF_CACHES-1:0] o_winner_onehot,
    output logic [PW-1:0]               o_winner_index,
    output logic                        o_valid
);
    logic [NUMBER_OF_CACHES-1:0] w_at_or_after;

    generate
        for (genvar gi = 0; gi < NUMBER_OF_CACHES; gi++) begin : g_mask
            assign w_at_or_after[gi] = i_request[gi] && (gi >= int'(i_pointer));
        end
    endgenerate

    // Lowest requester overall is the wrap-around fallback; any requester at or
    // after the pointer overrides it.
    always_comb begin
        o_winner_index  = '0;
        o_valid         = 1'b0;
        o_winner_onehot = '0;
        for (int i = NUMBER_OF_CACHES - 1; i >= 0; i--) begin
            if (i_request[i]) begin
                o_winner_index = PW'(i);
                o_valid        = 1'b1;
            end
        end
        for (int i = NUMBER_OF_CACHES - 1; i >= 0; i--) begin
            if (w_at_or_after[i]) begin
                o_winner_index = PW'(i);
            end
        end
        o_winner_onehot[o_winner_index] = o_valid;
    end
endmodule

// File: rtl/snoopy_bus_controller.sv
// Snoopy bus owner: arbitrates caches, broadcasts the command, gathers snoop
// responses and sequences the flush write and memory read against the RAM.
module snoopy_bus_controller
    import commands::*;
    import snoopy_bus_controller_pkg::*;
#(
    parameter int NUMBER_OF_CACHES = 4,
    parameter int ADDRESS_WIDTH    = 16,
    parameter int DATA_WIDTH       = 16
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [NUMBER_OF_CACHES-1:0] request,
    input  command_t                    commandIn [NUMBER_OF_CACHES],
    input  logic [ADDRESS_WIDTH-1:0]    addressIn [NUMBER_OF_CACHES],
    output logic [NUMBER_OF_CACHES-1:0] grant,
    output logic                        busValid,
    output command_t                    commandOut,
    output logic [ADDRESS_WIDTH-1:0]    addressOut,
    input  logic [NUMBER_OF_CACHES-1:0] sharedOut,
    input  logic [NUMBER_OF_CACHES-1:0] ramWriteRequired,
    input  logic [DATA_WIDTH-1:0]       flushData [NUMBER_OF_CACHES],
    output logic                        sharedIn,
    output logic [DATA_WIDTH-1:0]       dataOut,
    output logic [NUMBER_OF_CACHES-1:0] done,
    output logic                        ramRead,
    output logic                        ramWrite,
    output logic [ADDRESS_WIDTH-1:0]    ramAddress,
    output logic [DATA_WIDTH-1:0]       ramWriteData,
    input  logic [DATA_WIDTH-1:0]       ramReadData,
    input  logic                        ramAck,
    output logic                        protocolError
);
    localparam int PW = $clog2(NUMBER_OF_CACHES);

    state_t                      r_state;
    logic [PW-1:0]               r_pointer;
    logic [NUMBER_OF_CACHES-1:0] r_grant;
    logic                        r_bus_valid;
    command_t                    r_command;
    logic [ADDRESS_WIDTH-1:0]    r_address;
    logic                        r_shared;
    logic [DATA_WIDTH-1:0]       r_data;
    logic [NUMBER_OF_CACHES-1:0] r_done;
    logic                        r_ram_read;
    logic                        r_ram_write;
    logic [ADDRESS_WIDTH-1:0]    r_ram_address;
    logic [DATA_WIDTH-1:0]       r_ram_write_data;
    logic                        r_protocol_error;

    logic [NUMBER_OF_CACHES-1:0] w_win_onehot;
    logic [PW-1:0]               w_win_index;
    logic                        w_win_valid;
    logic [PW-1:0]               w_next_pointer;
    logic [NUMBER_OF_CACHES-1:0] w_flush_mask;
    logic                        w_flush_found;
    logic                        w_flush_multi;
    logic [PW-1:0]               w_flush_index;
    logic                        w_shared;

    round_robin_arbiter #(
        .NUMBER_OF_CACHES(NUMBER_OF_CACHES)
    ) u_arbiter (
        .i_request      (request),
        .i_pointer      (r_pointer),
        .o_winner_onehot(w_win_onehot),
        .o_winner_index (w_win_index),
        .o_valid        (w_win_valid)
    );

    assign w_next_pointer = (w_win_index == PW'(NUMBER_OF_CACHES - 1)) ? '0 : w_win_index + PW'(1);

    // The winner's own snoop response is masked out via the held grant.
    assign w_flush_mask  = ramWriteRequired & ~r_grant;
    assign w_flush_found = |w_flush_mask;
    assign w_flush_multi = |(w_flush_mask & (w_flush_mask - NUMBER_OF_CACHES'(1)));
    assign w_shared      = |(sharedOut & ~r_grant);

    always_comb begin
        w_flush_index = '0;
        for (int i = NUMBER_OF_CACHES - 1; i >= 0; i--) begin
            if (w_flush_mask[i]) begin
                w_flush_index = PW'(i);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state          <= IDLE;
            r_pointer        <= '0;
            r_grant          <= '0;
            r_bus_valid      <= 1'b0;
            r_command        <= NONE;
            r_address        <= '0;
            r_shared         <= 1'b0;
            r_data           <= '0;
            r_done           <= '0;
            r_ram_read       <= 1'b0;
            r_ram_write      <= 1'b0;
            r_ram_address    <= '0;
            r_ram_write_data <= '0;
            r_protocol_error <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_win_valid) begin
                        r_grant     <= w_win_onehot;
                        r_command   <= commandIn[w_win_index];
                        r_address   <= addressIn[w_win_index];
                        r_pointer   <= w_next_pointer;
                        r_bus_valid <= 1'b1;
                        r_state     <= SNOOP;
                    end
                end
                SNOOP: begin
                    r_bus_valid <= 1'b0;
                    r_shared    <= w_shared;
                    if (w_flush_multi) begin
                        r_protocol_error <= 1'b1;
                    end
                    if (w_flush_found) begin
                        r_ram_write      <= 1'b1;
                        r_ram_address    <= r_address;
                        r_ram_write_data <= flushData[w_flush_index];
                        r_state          <= FLUSH;
                    end else if (needs_memory_read(r_command)) begin
                        r_ram_read    <= 1'b1;
                        r_ram_address <= r_address;
                        r_state       <= MEM_READ;
                    end else begin
                        r_done  <= r_grant;
                        r_state <= DONE;
                    end
                end
                FLUSH: begin
                    if (ramAck) begin
                        r_ram_write <= 1'b0;
                        if (needs_memory_read(r_command)) begin
                            r_ram_read <= 1'b1;
                            r_state    <= MEM_READ;
                        end else begin
                            r_done  <= r_grant;
                            r_state <= DONE;
                        end
                    end
                end
                MEM_READ: begin
                    if (ramAck) begin
                        r_ram_read <= 1'b0;
                        r_data     <= ramReadData;
                        r_done     <= r_grant;
                        r_state    <= DONE;
                    end
                end
                DONE: begin
                    r_done    <= '0;
                    r_grant   <= '0;
                    r_command <= NONE;
                    r_shared  <= 1'b0;
                    r_state   <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign grant         = r_grant;
    assign busValid      = r_bus_valid;
    assign commandOut    = r_command;
    assign addressOut    = r_address;
    assign sharedIn      = r_shared;
    assign dataOut       = r_data;
    assign done          = r_done;
    assign ramRead       = r_ram_read;
    assign ramWrite      = r_ram_write;
    assign ramAddress    = r_ram_address;
    assign ramWriteData  = r_ram_write_data;
    assign protocolError = r_protocol_error;
endmodule

// File: tb/tb_snoopy_bus_controller.sv
// Directed bench for snoopy_bus_controller: one task per scenario, inline checks.
module tb_snoopy_bus_controller;
    import commands::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  request = '0;
    command_t    commandIn [4];
    logic [15:0] addressIn [4];
    logic [3:0]  grant;
    logic        busValid;
    command_t    commandOut;
    logic [15:0] addressOut;
    logic [3:0]  sharedOut = '0;
    logic [3:0]  ramWriteRequired = '0;
    logic [15:0] flushData [4];
    logic        sharedIn;
    logic [15:0] dataOut;
    logic [3:0]  done;
    logic        ramRead;
    logic        ramWrite;
    logic [15:0] ramAddress;
    logic [15:0] ramWriteData;
    logic [15:0] ramReadData = '0;
    logic        ramAck = 1'b0;
    logic        protocolError;

    int errors = 0;
    int checks = 0;
    logic overlap_seen = 1'b0;

    snoopy_bus_controller #(
        .NUMBER_OF_CACHES(4),
        .ADDRESS_WIDTH(16),
        .DATA_WIDTH(16)
    ) dut (
        .clock(clock), .reset(reset), .request(request),
        .commandIn(commandIn), .addressIn(addressIn),
        .grant(grant), .busValid(busValid), .commandOut(commandOut), .addressOut(addressOut),
        .sharedOut(sharedOut), .ramWriteRequired(ramWriteRequired), .flushData(flushData),
        .sharedIn(sharedIn), .dataOut(dataOut), .done(done),
        .ramRead(ramRead), .ramWrite(ramWrite), .ramAddress(ramAddress),
        .ramWriteData(ramWriteData), .ramReadData(ramReadData), .ramAck(ramAck),
        .protocolError(protocolError)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (ramRead && ramWrite) overlap_seen <= 1'b1;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL reset_grant: got %b want 0000", grant); end
        checks++; if (done !== 4'b0000) begin errors++; $display("FAIL reset_done: got %b want 0000", done); end
        checks++; if (busValid !== 1'b0 || sharedIn !== 1'b0) begin errors++; $display("FAIL reset_valid_shared: got %b%b want 00", busValid, sharedIn); end
        checks++; if (ramRead !== 1'b0 || ramWrite !== 1'b0) begin errors++; $display("FAIL reset_ram_req: got %b%b want 00", ramRead, ramWrite); end
        checks++; if (protocolError !== 1'b0) begin errors++; $display("FAIL reset_perr: got %b want 0", protocolError); end
        checks++; if (commandOut !== NONE) begin errors++; $display("FAIL reset_cmd: got %0d want 0", commandOut); end
        checks++; if (addressOut !== 16'h0 || dataOut !== 16'h0 || ramAddress !== 16'h0 || ramWriteData !== 16'h0) begin
            errors++; $display("FAIL reset_data: got %h %h %h %h want all 0000", addressOut, dataOut, ramAddress, ramWriteData); end
        reset = 1'b0;
        $display("txn reset: outputs cleared");
    endtask

    task automatic test_invalidate();
        commandIn[2] = BUS_INVALIDATE; addressIn[2] = 16'h0040; request = 4'b0100;
        ramAck = 1'b1;  // ack outside FLUSH/MEM_READ must be ignored
        tick();
        checks++; if (busValid !== 1'b1) begin errors++; $display("FAIL inv_busvalid: got %b want 1", busValid); end
        checks++; if (commandOut !== BUS_INVALIDATE || addressOut !== 16'h0040) begin
            errors++; $display("FAIL inv_broadcast: got cmd %0d addr %h want 3 0040", commandOut, addressOut); end
        checks++; if (grant !== 4'b0100 || done !== 4'b0000) begin errors++; $display("FAIL inv_snoop_grant: got g %b d %b want 0100 0000", grant, done); end
        tick();
        checks++; if (done !== 4'b0100) begin errors++; $display("FAIL inv_done: got %b want 0100", done); end
        checks++; if (busValid !== 1'b0 || ramRead !== 1'b0 || ramWrite !== 1'b0) begin
            errors++; $display("FAIL inv_done_flags: got v%b r%b w%b want 000", busValid, ramRead, ramWrite); end
        request = 4'b0000; ramAck = 1'b0;
        tick();
        checks++; if (grant !== 4'b0000 || done !== 4'b0000 || commandOut !== NONE) begin
            errors++; $display("FAIL inv_idle: got g %b d %b cmd %0d want 0000 0000 0", grant, done, commandOut); end
        $display("txn invalidate: cache 2 addr 0040 done=%b", 4'b0100);
    endtask

    task automatic test_read_shared();
        commandIn[0] = BUS_READ; addressIn[0] = 16'h0010; request = 4'b0001; sharedOut = 4'b0010;
        tick();
        checks++; if (grant !== 4'b0001 || busValid !== 1'b1) begin errors++; $display("FAIL rd_grant: got %b v%b want 0001 1", grant, busValid); end
        tick();
        checks++; if (ramRead !== 1'b1 || ramAddress !== 16'h0010) begin errors++; $display("FAIL rd_ramread: got r%b a %h want 1 0010", ramRead, ramAddress); end
        checks++; if (sharedIn !== 1'b1) begin errors++; $display("FAIL rd_shared: got %b want 1", sharedIn); end
        tick();
        tick();
        checks++; if (ramRead !== 1'b1 || done !== 4'b0000) begin errors++; $display("FAIL rd_wait: got r%b d %b want 1 0000", ramRead, done); end
        ramAck = 1'b1; ramReadData = 16'hBEEF;
        tick();
        ramAck = 1'b0; ramReadData = 16'h0000;
        checks++; if (done !== 4'b0001) begin errors++; $display("FAIL rd_done: got %b want 0001", done); end
        checks++; if (dataOut !== 16'hBEEF || ramRead !== 1'b0 || sharedIn !== 1'b1) begin
            errors++; $display("FAIL rd_data: got %h r%b s%b want BEEF 0 1", dataOut, ramRead, sharedIn); end
        request = 4'b0000; sharedOut = 4'b0000;
        tick();
        checks++; if (sharedIn !== 1'b0 || grant !== 4'b0000 || dataOut !== 16'hBEEF) begin
            errors++; $display("FAIL rd_idle: got s%b g %b d %h want 0 0000 BEEF", sharedIn, grant, dataOut); end
        $display("txn read_shared: cache 0 addr 0010 data=%h", dataOut);
    endtask

    task automatic test_read_flush();
        commandIn[1] = BUS_READ; addressIn[1] = 16'h0020; request = 4'b0010;
        ramWriteRequired = 4'b1000; flushData[3] = 16'h1234;
        tick();
        checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL fl_grant: got %b want 0010", grant); end
        tick();
        ramWriteRequired = 4'b0000; flushData[3] = 16'h0000;
        checks++; if (ramWrite !== 1'b1 || ramWriteData !== 16'h1234 || ramAddress !== 16'h0020 || ramRead !== 1'b0) begin
            errors++; $display("FAIL fl_write: got w%b d %h a %h r%b want 1 1234 0020 0", ramWrite, ramWriteData, ramAddress, ramRead); end
        tick();
        checks++; if (ramWrite !== 1'b1) begin errors++; $display("FAIL fl_hold: got %b want 1", ramWrite); end
        ramAck = 1'b1;
        tick();
        ramAck = 1'b0;
        checks++; if (ramWrite !== 1'b0 || ramRead !== 1'b1 || ramAddress !== 16'h0020) begin
            errors++; $display("FAIL fl_to_read: got w%b r%b a %h want 0 1 0020", ramWrite, ramRead, ramAddress); end
        tick();
        checks++; if (ramRead !== 1'b1 || done !== 4'b0000) begin errors++; $display("FAIL fl_read_hold: got r%b d %b want 1 0000", ramRead, done); end
        ramAck = 1'b1; ramReadData = 16'h5678;
        tick();
        ramAck = 1'b0; ramReadData = 16'h0000;
        checks++; if (done !== 4'b0010 || dataOut !== 16'h5678 || sharedIn !== 1'b0) begin
            errors++; $display("FAIL fl_done: got d %b data %h s%b want 0010 5678 0", done, dataOut, sharedIn); end
        request = 4'b0000;
        tick();
        $display("txn read_flush: cache 1 addr 0020 flushed 1234 data=%h", dataOut);
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_onehot;
        int exp_idx;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            commandIn[i] = BUS_INVALIDATE;
            addressIn[i] = 16'h0100 * 16'(i + 1);
        end
        request = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            exp_idx = k % 4;
            exp_onehot = 4'b0001 << exp_idx;
            tick();
            checks++; if (grant !== exp_onehot || addressOut !== 16'h0100 * 16'(exp_idx + 1)) begin
                errors++; $display("FAIL rr_grant%0d: got %b addr %h want %b addr %h", k, grant, addressOut, exp_onehot, 16'h0100 * 16'(exp_idx + 1)); end
            tick();
            checks++; if (done !== exp_onehot) begin errors++; $display("FAIL rr_done%0d: got %b want %b", k, done, exp_onehot); end
            tick();
            checks++; if (grant !== 4'b0000 || busValid !== 1'b0) begin errors++; $display("FAIL rr_idle%0d: got %b v%b want 0000 0", k, grant, busValid); end
            $display("txn round_robin: grant to cache %0d", exp_idx);
        end
        request = 4'b0000;
        tick();
    endtask

    task automatic test_protocol_error();
        commandIn[0] = BUS_INVALIDATE; addressIn[0] = 16'h0080; request = 4'b0001;
        ramWriteRequired = 4'b1100; flushData[2] = 16'hAAAA; flushData[3] = 16'hBBBB;
        tick();
        checks++; if (grant !== 4'b0001 || protocolError !== 1'b0) begin errors++; $display("FAIL pe_snoop: got g %b e%b want 0001 0", grant, protocolError); end
        tick();
        ramWriteRequired = 4'b0000;
        checks++; if (protocolError !== 1'b1) begin errors++; $display("FAIL pe_rise: got %b want 1", protocolError); end
        checks++; if (ramWrite !== 1'b1 || ramWriteData !== 16'hAAAA || ramAddress !== 16'h0080) begin
            errors++; $display("FAIL pe_flush: got w%b d %h a %h want 1 AAAA 0080", ramWrite, ramWriteData, ramAddress); end
        ramAck = 1'b1;
        tick();
        ramAck = 1'b0;
        checks++; if (done !== 4'b0001 || ramWrite !== 1'b0 || ramRead !== 1'b0) begin
            errors++; $display("FAIL pe_done: got d %b w%b r%b want 0001 0 0", done, ramWrite, ramRead); end
        request = 4'b0000;
        tick();
        tick();
        checks++; if (protocolError !== 1'b1) begin errors++; $display("FAIL pe_sticky: got %b want 1", protocolError); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (protocolError !== 1'b0) begin errors++; $display("FAIL pe_clear: got %b want 0", protocolError); end
        $display("txn protocol_error: cache 0 addr 0080 flushed AAAA");
    endtask

    task automatic test_reset_mid();
        commandIn[3] = BUS_READ; addressIn[3] = 16'h00F0; request = 4'b1000;
        tick();
        tick();
        checks++; if (ramRead !== 1'b1 || grant !== 4'b1000) begin errors++; $display("FAIL rm_memread: got r%b g %b want 1 1000", ramRead, grant); end
        reset = 1'b1;
        tick();
        reset = 1'b0; request = 4'b0000;
        checks++; if (grant !== 4'b0000 || ramRead !== 1'b0 || done !== 4'b0000 || commandOut !== NONE) begin
            errors++; $display("FAIL rm_abort: got g %b r%b d %b cmd %0d want 0000 0 0000 0", grant, ramRead, done, commandOut); end
        ramAck = 1'b1; ramReadData = 16'hDEAD;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (done !== 4'b0000 || ramRead !== 1'b0 || busValid !== 1'b0) begin
                errors++; $display("FAIL rm_quiet%0d: got d %b r%b v%b want 0000 0 0", k, done, ramRead, busValid); end
        end
        ramAck = 1'b0; ramReadData = 16'h0000;
        $display("txn reset_mid: cache 3 aborted");
    endtask

    task automatic test_no_overlap();
        checks++; if (overlap_seen !== 1'b0) begin errors++; $display("FAIL ram_overlap: got %b want 0", overlap_seen); end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            commandIn[i] = NONE;
            addressIn[i] = '0;
            flushData[i] = '0;
        end
        test_reset();
        test_invalidate();
        test_read_shared();
        test_read_flush();
        test_round_robin();
        test_protocol_error();
        test_reset_mid();
        test_no_overlap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
